csr_file: RTL and testbench

//  Machine-mode CSR file for the RV64 core; successor to the four-register CSR bank.
//  - Combinational read port for ID; one write port from EX.
//  - Hardware trap entry/exit: ecall, mret and machine-timer interrupt.
//  - Free-running mcycle/minstret counters.
//  - Supplies the redirect target (trap vector or mepc) to the PC unit.

---
 rtl/csr_pkg.sv | 37 +++
 rtl/csr_if.sv | 34 +++
 rtl/csr_counter.sv | 24 ++
 rtl/csr_file.sv | 158 +++++++++++++++
 tb/tb_csr_file.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// CSR file package: addresses, mstatus/mie/mip bit positions, cause codes, mtvec mode.
package csr_pkg;

    localparam int unsigned CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MIP      = 12'h344;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MINSTRET = 12'hB02;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam int unsigned MIE_MTIE = 7;
    localparam int unsigned MIP_MTIP = 7;

    localparam int unsigned CAUSE_ECALL_M = 11;
    localparam int unsigned CAUSE_MTI     = 7;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1
    } mtvec_mode_e;

    // Reserved MODE encodings (2, 3) collapse to direct mode.
    function automatic mtvec_mode_e legal_mtvec_mode(input logic [1:0] mode);
        return (mode == 2'd1) ? MTVEC_VECTORED : MTVEC_DIRECT;
    endfunction

endpackage

// File: rtl/csr_if.sv
// CSR file bus: ID read port, EX write port, trap/return events, timer irq, redirect.
// master = pipeline side, slave = csr_file.
interface csr_if
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 64
) ();
    logic [CSR_AW-1:0] csr_raddr_i;
    logic [XLEN-1:0]   csr_rdata_o;
    logic [CSR_AW-1:0] csr_waddr_i;
    logic [XLEN-1:0]   csr_wdata_i;
    logic              csr_wen_i;
    logic              ecall_i;
    logic              mret_i;
    logic [XLEN-1:0]   trap_pc_i;
    logic              timer_irq_i;
    logic              irq_req_o;
    logic              irq_ack_i;
    logic              instret_i;
    logic              redirect_o;
    logic [XLEN-1:0]   redirect_pc_o;

    modport master (
        output csr_raddr_i, csr_waddr_i, csr_wdata_i, csr_wen_i,
        output ecall_i, mret_i, trap_pc_i, timer_irq_i, irq_ack_i, instret_i,
        input  csr_rdata_o, irq_req_o, redirect_o, redirect_pc_o
    );

    modport slave (
        input  csr_raddr_i, csr_waddr_i, csr_wdata_i, csr_wen_i,
        input  ecall_i, mret_i, trap_pc_i, timer_irq_i, irq_ack_i, instret_i,
        output csr_rdata_o, irq_req_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/csr_counter.sv
// Free-running XLEN counter with software load; a load wins over that cycle's increment.
// Ports: clk, rst (async, active-low), wen/wdata (load), inc (add 1), count (registered).
module csr_counter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [XLEN-1:0] wdata,
    input  logic            inc,
    output logic [XLEN-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (wen) begin
            count <= wdata;
        end else begin
            count <= count + XLEN'(inc);
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, one write port, ecall/mret/timer-interrupt
// trap handling with PC redirect, mcycle/minstret counters.
// Ports: clk, rst (async, active-low), io (csr_if.slave: read/write ports, trap events,
// timer irq request/ack, instret, redirect/redirect_pc).
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter logic [XLEN-1:0] RESET_MSTAT = XLEN'(64'ha00001800),
    parameter bit              HAS_CNTRS   = 1'b1
) (
    input logic  clk,
    input logic  rst,
    csr_if.slave io
);

    logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
    logic [XLEN-1:0] mcycle, minstret;
    logic [XLEN-1:0] mstatus_nxt;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] redirect_pc;
    logic            irq_req, redirect;
    logic            take_irq, take_ecall, take_mret, take_trap;

    logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause;
    logic we_mcycle, we_minstret;

    // Write-port address decode
    assign we_mstatus  = io.csr_wen_i && (io.csr_waddr_i == CSR_MSTATUS);
    assign we_mie      = io.csr_wen_i && (io.csr_waddr_i == CSR_MIE);
    assign we_mtvec    = io.csr_wen_i && (io.csr_waddr_i == CSR_MTVEC);
    assign we_mscratch = io.csr_wen_i && (io.csr_waddr_i == CSR_MSCRATCH);
    assign we_mepc     = io.csr_wen_i && (io.csr_waddr_i == CSR_MEPC);
    assign we_mcause   = io.csr_wen_i && (io.csr_waddr_i == CSR_MCAUSE);
    assign we_mcycle   = io.csr_wen_i && (io.csr_waddr_i == CSR_MCYCLE);
    assign we_minstret = io.csr_wen_i && (io.csr_waddr_i == CSR_MINSTRET);

    // Performance counters
    if (HAS_CNTRS) begin : g_cntrs
        csr_counter #(.XLEN(XLEN)) u_mcycle (
            .clk   (clk),
            .rst   (rst),
            .wen   (we_mcycle),
            .wdata (io.csr_wdata_i),
            .inc   (1'b1),
            .count (mcycle)
        );
        csr_counter #(.XLEN(XLEN)) u_minstret (
            .clk   (clk),
            .rst   (rst),
            .wen   (we_minstret),
            .wdata (io.csr_wdata_i),
            .inc   (io.instret_i),
            .count (minstret)
        );
    end else begin : g_no_cntrs
        assign mcycle   = '0;
        assign minstret = '0;
    end

    // Read mux; mip shows only the live MTIP line
    always_comb begin
        rdata = '0;
        case (io.csr_raddr_i)
            CSR_MSTATUS:  rdata = mstatus;
            CSR_MIE:      rdata = mie;
            CSR_MTVEC:    rdata = mtvec;
            CSR_MSCRATCH: rdata = mscratch;
            CSR_MEPC:     rdata = mepc;
            CSR_MCAUSE:   rdata = mcause;
            CSR_MIP:      rdata[MIP_MTIP] = io.timer_irq_i;
            CSR_MCYCLE:   rdata = mcycle;
            CSR_MINSTRET: rdata = minstret;
            default:      ;
        endcase
    end

    // Event arbitration (irq ack > ecall > mret), redirect target, next mstatus
    always_comb begin
        irq_req     = mstatus[MSTATUS_MIE] & mie[MIE_MTIE] & io.timer_irq_i;
        take_irq    = io.irq_ack_i & irq_req;
        take_ecall  = io.ecall_i & ~take_irq;
        take_mret   = io.mret_i & ~take_irq & ~take_ecall;
        take_trap   = take_irq | take_ecall;
        redirect    = take_trap | take_mret;
        trap_base   = {mtvec[XLEN-1:2], 2'b00};
        redirect_pc = '0;
        if (take_trap) begin
            redirect_pc = trap_base;
            if (take_irq && (mtvec_mode_e'(mtvec[1:0]) == MTVEC_VECTORED)) begin
                redirect_pc = trap_base + XLEN'(4 * CAUSE_MTI);
            end
        end else if (take_mret) begin
            redirect_pc = mepc;
        end

        // Trap/mret fields land on top of any same-cycle software write.
        mstatus_nxt = we_mstatus ? io.csr_wdata_i : mstatus;
        if (take_trap) begin
            mstatus_nxt[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
            mstatus_nxt[MSTATUS_MIE]                   = 1'b0;
            mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (take_mret) begin
            mstatus_nxt[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
            mstatus_nxt[MSTATUS_MPIE]                  = 1'b1;
            mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end
    end

    // Outputs forced low while reset is asserted
    assign io.csr_rdata_o   = rst ? rdata : '0;
    assign io.irq_req_o     = rst & irq_req;
    assign io.redirect_o    = rst & redirect;
    assign io.redirect_pc_o = rst ? redirect_pc : '0;

    // CSR state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus  <= RESET_MSTAT;
            mie      <= '0;
            mtvec    <= RESET_MTVEC;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            mstatus <= mstatus_nxt;
            if (we_mie) begin
                mie <= io.csr_wdata_i;
            end
            if (we_mtvec) begin
                mtvec <= {io.csr_wdata_i[XLEN-1:2], legal_mtvec_mode(io.csr_wdata_i[1:0])};
            end
            if (we_mscratch) begin
                mscratch <= io.csr_wdata_i;
            end
            if (take_trap) begin
                mepc   <= {io.trap_pc_i[XLEN-1:2], 2'b00};
                mcause <= take_irq ? {1'b1, (XLEN-1)'(CAUSE_MTI)} : XLEN'(CAUSE_ECALL_M);
            end else begin
                if (we_mepc) begin
                    mepc <= {io.csr_wdata_i[XLEN-1:2], 2'b00};
                end
                if (we_mcause) begin
                    mcause <= io.csr_wdata_i;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // The pipeline may only acknowledge an interrupt that is being requested.
    ack_needs_req: assert property (@(posedge clk) disable iff (!rst)
        io.irq_ack_i |-> io.irq_req_o);
`endif

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver predicts each cycle's outputs from a reference
// model and queues them; a negedge monitor pops and compares against the DUT.
module tb_csr_file;

    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    csr_if #(.XLEN(XLEN)) bus ();

    csr_file #(
        .XLEN        (XLEN),
        .RESET_MTVEC (64'h0),
        .RESET_MSTAT (64'ha00001800),
        .HAS_CNTRS   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [11:0] raddr;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        ecall;
        logic        mret;
        logic        ack;
        logic        instret;
        logic        timer;
        logic [63:0] trap_pc;
    } stim_t;

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        irq;
        logic        redir;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state
    logic [63:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mcycle, r_minstret;

    logic        tmr = 1'b0;
    bit          pin_rd_en = 1'b0;
    logic [63:0] pin_rd;
    bit          pin_pc_en = 1'b0;
    logic [63:0] pin_pc;

    function automatic void model_reset();
        r_mstatus  = 64'ha00001800;
        r_mie      = 64'h0;
        r_mtvec    = 64'h0;
        r_mscratch = 64'h0;
        r_mepc     = 64'h0;
        r_mcause   = 64'h0;
        r_mcycle   = 64'h0;
        r_minstret = 64'h0;
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a, input logic timer);
        case (a)
            12'h300: return r_mstatus;
            12'h304: return r_mie;
            12'h305: return r_mtvec;
            12'h340: return r_mscratch;
            12'h341: return r_mepc;
            12'h342: return r_mcause;
            12'h344: return timer ? 64'h80 : 64'h0;
            12'hB00: return r_mcycle;
            12'hB02: return r_minstret;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic model_irq(input logic timer);
        return r_mstatus[3] && r_mie[7] && timer;
    endfunction

    function automatic exp_t predict(input stim_t s, input string tag);
        exp_t e;
        logic t_irq, t_ecall, t_mret;
        t_irq   = s.ack && model_irq(s.timer);
        t_ecall = s.ecall && !t_irq;
        t_mret  = s.mret && !t_irq && !t_ecall;
        e.tag   = tag;
        e.rdata = model_read(s.raddr, s.timer);
        e.irq   = model_irq(s.timer);
        e.redir = t_irq || t_ecall || t_mret;
        e.pc    = 64'h0;
        if (t_irq || t_ecall)
            e.pc = (r_mtvec & ~64'h3) + ((t_irq && r_mtvec[1:0] == 2'd1) ? 64'd28 : 64'd0);
        else if (t_mret)
            e.pc = r_mepc;
        return e;
    endfunction

    function automatic void commit(input stim_t s);
        logic [63:0] o_st;
        logic t_irq, t_ecall, t_mret;
        o_st    = r_mstatus;
        t_irq   = s.ack && model_irq(s.timer);
        t_ecall = s.ecall && !t_irq;
        t_mret  = s.mret && !t_irq && !t_ecall;
        r_mcycle   = r_mcycle + 64'd1;
        r_minstret = r_minstret + (s.instret ? 64'd1 : 64'd0);
        if (s.wen) begin
            case (s.waddr)
                12'h300: r_mstatus  = s.wdata;
                12'h304: r_mie      = s.wdata;
                12'h305: r_mtvec    = (s.wdata[1:0] >= 2'd2) ? (s.wdata & ~64'h3) : s.wdata;
                12'h340: r_mscratch = s.wdata;
                12'h341: r_mepc     = s.wdata & ~64'h3;
                12'h342: r_mcause   = s.wdata;
                12'hB00: r_mcycle   = s.wdata;
                12'hB02: r_minstret = s.wdata;
                default: ;
            endcase
        end
        if (t_irq || t_ecall) begin
            r_mepc       = s.trap_pc & ~64'h3;
            r_mcause     = t_irq ? 64'h8000000000000007 : 64'd11;
            r_mstatus[7] = o_st[3];
            r_mstatus[3] = 1'b0;
            r_mstatus[12:11] = 2'b11;
        end else if (t_mret) begin
            r_mstatus[3] = o_st[7];
            r_mstatus[7] = 1'b1;
            r_mstatus[12:11] = 2'b11;
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.raddr   = 12'h7C0;
        s.wen     = 1'b0;
        s.waddr   = 12'h000;
        s.wdata   = 64'h0;
        s.ecall   = 1'b0;
        s.mret    = 1'b0;
        s.ack     = 1'b0;
        s.instret = 1'b0;
        s.timer   = tmr;
        s.trap_pc = 64'h0;
        return s;
    endfunction

    // One clock: drive at posedge+1, queue expectation, advance, update model.
    task automatic step(input stim_t s, input logic rst_lvl, input string tag);
        exp_t e;
        rst                 = rst_lvl;
        bus.csr_raddr_i     = s.raddr;
        bus.csr_wen_i       = s.wen;
        bus.csr_waddr_i     = s.waddr;
        bus.csr_wdata_i     = s.wdata;
        bus.ecall_i         = s.ecall;
        bus.mret_i          = s.mret;
        bus.irq_ack_i       = s.ack;
        bus.instret_i       = s.instret;
        bus.timer_irq_i     = s.timer;
        bus.trap_pc_i       = s.trap_pc;
        if (!rst_lvl) begin
            model_reset();
            e.tag = tag; e.rdata = 64'h0; e.irq = 1'b0; e.redir = 1'b0; e.pc = 64'h0;
        end else begin
            e = predict(s, tag);
        end
        if (pin_rd_en) e.rdata = pin_rd;
        if (pin_pc_en) begin e.redir = 1'b1; e.pc = pin_pc; end
        pin_rd_en = 1'b0;
        pin_pc_en = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        if (rst_lvl) commit(s);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] v, input string tag);
        stim_t s;
        s = idle(); s.raddr = a;
        pin_rd_en = 1'b1; pin_rd = v;
        step(s, 1'b1, tag);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] v, input string tag);
        stim_t s;
        s = idle(); s.wen = 1'b1; s.waddr = a; s.wdata = v;
        step(s, 1'b1, tag);
    endtask

    task automatic ev(input stim_t s, input logic [63:0] pc, input string tag);
        pin_pc_en = 1'b1; pin_pc = pc;
        step(s, 1'b1, tag);
    endtask

    // Monitor: compare every queued expectation against the DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (bus.csr_rdata_o !== e.rdata) begin
                    n_bad++;
                    $display("FAIL %s rdata: got %h want %h", e.tag, bus.csr_rdata_o, e.rdata);
                end
                if (bus.irq_req_o !== e.irq) begin
                    n_bad++;
                    $display("FAIL %s irq_req: got %b want %b", e.tag, bus.irq_req_o, e.irq);
                end
                if (bus.redirect_o !== e.redir) begin
                    n_bad++;
                    $display("FAIL %s redirect: got %b want %b", e.tag, bus.redirect_o, e.redir);
                end
                if (e.redir && bus.redirect_pc_o !== e.pc) begin
                    n_bad++;
                    $display("FAIL %s redirect_pc: got %h want %h", e.tag, bus.redirect_pc_o, e.pc);
                end
            end
        end
    end

    logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'h301};

    initial begin
        stim_t s;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset held, then release
        s = idle(); s.raddr = 12'h300;
        pin_rd_en = 1'b1; pin_rd = 64'h0;
        step(s, 1'b0, "in_reset");
        rd(12'h300, 64'ha00001800, "rst_mstatus");
        rd(12'h305, 64'h0, "rst_mtvec");
        rd(12'h341, 64'h0, "rst_mepc");
        rd(12'h342, 64'h0, "rst_mcause");
        rd(12'h7C0, 64'h0, "rst_unknown");

        // Ecall then mret
        wr(12'h305, 64'h80001000, "wr_mtvec");
        wr(12'h300, 64'ha00001808, "wr_mstatus");
        s = idle(); s.ecall = 1'b1; s.trap_pc = 64'h80000104;
        ev(s, 64'h80001000, "ecall");
        rd(12'h341, 64'h80000104, "ecall_mepc");
        rd(12'h342, 64'd11, "ecall_mcause");
        rd(12'h300, 64'ha00001880, "ecall_mstatus");
        s = idle(); s.mret = 1'b1;
        ev(s, 64'h80000104, "mret");
        rd(12'h300, 64'ha00001888, "mret_mstatus");

        // Vectored timer interrupt
        wr(12'h305, 64'h80002001, "wr_mtvec_vec");
        wr(12'h304, 64'h80, "wr_mie");
        tmr = 1'b1;
        rd(12'h344, 64'h80, "mip_mtip");
        s = idle(); s.ack = 1'b1; s.trap_pc = 64'h80000200;
        ev(s, 64'h8000201C, "irq_take");
        rd(12'h342, 64'h8000000000000007, "irq_mcause");

        // Priority: ack + ecall + mepc write
        wr(12'h300, 64'ha00001808, "wr_mstatus2");
        s = idle(); s.ack = 1'b1; s.ecall = 1'b1; s.trap_pc = 64'h80000300;
        s.wen = 1'b1; s.waddr = 12'h341; s.wdata = 64'h1234;
        ev(s, 64'h8000201C, "prio_irq");
        rd(12'h342, 64'h8000000000000007, "prio_mcause");
        rd(12'h341, 64'h80000300, "prio_mepc");
        tmr = 1'b0;
        s = idle(); s.ecall = 1'b1; s.mret = 1'b1; s.trap_pc = 64'h80000400;
        ev(s, 64'h80002000, "ecall_over_mret");
        rd(12'h341, 64'h80000400, "eom_mepc");
        rd(12'h342, 64'd11, "eom_mcause");

        // Counters
        wr(12'hB00, 64'hFFFFFFFFFFFFFFFE, "wr_mcycle");
        rd(12'hB00, 64'hFFFFFFFFFFFFFFFE, "mcycle_fe");
        rd(12'hB00, 64'hFFFFFFFFFFFFFFFF, "mcycle_ff");
        rd(12'hB00, 64'h0, "mcycle_wrap");
        wr(12'hB02, 64'h0, "wr_minstret");
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.instret = 1'b1;
            step(s, 1'b1, "instret");
        end
        rd(12'hB02, 64'd3, "minstret_3");

        // Write legalisation
        wr(12'h305, 64'h80003003, "wr_mtvec_bad");
        rd(12'h305, 64'h80003000, "mtvec_legal");
        wr(12'h341, 64'h1237, "wr_mepc_odd");
        rd(12'h341, 64'h1234, "mepc_align");
        wr(12'h344, 64'hFFFF, "wr_mip");
        rd(12'h344, 64'h0, "mip_ro");

        // Asynchronous reset mid-run
        s = idle(); s.raddr = 12'h341;
        pin_rd_en = 1'b1; pin_rd = 64'h0;
        step(s, 1'b0, "mid_reset");
        rd(12'h341, 64'h0, "post_rst_mepc");
        rd(12'h300, 64'ha00001800, "post_rst_mstatus");

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) tmr = ~tmr;
            s = idle();
            s.raddr   = addrs[$urandom_range(0, 10)];
            s.wen     = ($urandom_range(0, 2) == 0);
            s.waddr   = addrs[$urandom_range(0, 10)];
            s.wdata   = {$urandom, $urandom};
            s.ecall   = ($urandom_range(0, 15) == 0);
            s.mret    = ($urandom_range(0, 15) == 0);
            s.instret = 1'($urandom_range(0, 1));
            s.trap_pc = {$urandom, $urandom};
            s.ack     = model_irq(s.timer) && ($urandom_range(0, 1) == 1);
            step(s, 1'b1, "rand");
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
